// File: rtl/ecc_serial_host.sv
// ecc_serial_host: host-side end of the ECC core bit-serial link.
// Serializes m/P and nP jobs MSB-first toward the ECC wrapper and
// deserializes the wrapper's mP / mnP result streams into parallel words.
// Optional protocol checker: define ECC_HOST_CHECK_EN to enable rx_err.
module ecc_serial_host #(
  parameter int MAX_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_mp_start,
  input  logic                tx_np_start,
  input  logic [1:0]          tx_mode,
  input  logic [MAX_BITS-1:0] tx_a,
  input  logic [MAX_BITS-1:0] tx_b,
  input  logic [MAX_BITS-1:0] tx_prime,
  input  logic [MAX_BITS-1:0] tx_Px,
  input  logic [MAX_BITS-1:0] tx_Py,
  input  logic [MAX_BITS-1:0] tx_m,
  input  logic [MAX_BITS-1:0] tx_nPx,
  input  logic [MAX_BITS-1:0] tx_nPy,
  output logic                tx_ready,
  output logic                o_m_P_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_b,
  output logic                o_prime,
  output logic                o_Px,
  output logic                o_Py,
  output logic                o_m,
  output logic                o_nP_valid,
  output logic                o_nPx,
  output logic                o_nPy,
  input  logic                i_mP_valid,
  input  logic                i_mPx,
  input  logic                i_mPy,
  input  logic                i_mnP_valid,
  input  logic                i_mnPx,
  input  logic                i_mnPy,
  output logic [MAX_BITS-1:0] rx_mPx,
  output logic [MAX_BITS-1:0] rx_mPy,
  output logic [MAX_BITS-1:0] rx_mnPx,
  output logic [MAX_BITS-1:0] rx_mnPy,
  output logic                rx_mP_done,
  output logic                rx_mnP_done,
  output logic                rx_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MP_VALID, S_MODE, S_MP_DATA, S_GAP, S_NP_VALID, S_NP_DATA
  } state_t;

  // Operand size minus one for a mode code (32/64/128/256 bits).
  function automatic logic [7:0] n_minus_1(input logic [1:0] mode);
    case (mode)
      2'b00:   n_minus_1 = 8'd31;
      2'b01:   n_minus_1 = 8'd63;
      2'b10:   n_minus_1 = 8'd127;
      default: n_minus_1 = 8'd255;
    endcase
  endfunction

  // Left-align the low N bits so the serializer always emits the top bit.
  function automatic logic [MAX_BITS-1:0] align(input logic [MAX_BITS-1:0] val,
                                                input logic [1:0] mode);
    case (mode)
      2'b00:   align = {val[31:0],  {(MAX_BITS-32){1'b0}}};
      2'b01:   align = {val[63:0],  {(MAX_BITS-64){1'b0}}};
      2'b10:   align = {val[127:0], {(MAX_BITS-128){1'b0}}};
      default: align = val;
    endcase
  endfunction

  state_t              state;
  logic [1:0]          mode_reg;
  logic                mode_sent;
  logic                mode_phase;
  logic [7:0]          tx_cnt;
  logic [7:0]          rx_nm1;
  // sh_px/sh_py also hold nPx/nPy: the two frame types never overlap.
  logic [MAX_BITS-1:0] sh_a, sh_b, sh_prime, sh_px, sh_py, sh_m;

  assign rx_nm1 = n_minus_1(mode_reg);

  // Transmit FSM: frame sequencing, operand shift registers, registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      mode_reg <= 2'b00;
      mode_sent <= 1'b0;
      mode_phase <= 1'b0;
      tx_cnt <= 8'd0;
      tx_ready <= 1'b1;
      {o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m} <= 8'd0;
      {o_nP_valid, o_nPx, o_nPy} <= 3'd0;
      {sh_a, sh_b, sh_prime, sh_px, sh_py, sh_m} <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_mp_start) begin
            state <= S_MP_VALID;
            o_m_P_valid <= 1'b1;
            tx_ready <= 1'b0;
            mode_reg <= tx_mode;
            mode_sent <= 1'b1;
            sh_a <= align(tx_a, tx_mode);
            sh_b <= align(tx_b, tx_mode);
            sh_prime <= align(tx_prime, tx_mode);
            sh_px <= align(tx_Px, tx_mode);
            sh_py <= align(tx_Py, tx_mode);
            sh_m <= align(tx_m, tx_mode);
          end else if (tx_np_start && mode_sent) begin
            state <= S_NP_VALID;
            o_nP_valid <= 1'b1;
            tx_ready <= 1'b0;
            sh_px <= align(tx_nPx, mode_reg);
            sh_py <= align(tx_nPy, mode_reg);
          end
        end
        S_MP_VALID: begin
          o_m_P_valid <= 1'b0;
          o_mode <= mode_reg[1];
          mode_phase <= 1'b0;
          state <= S_MODE;
        end
        S_MODE: begin
          if (!mode_phase) begin
            o_mode <= mode_reg[0];
            mode_phase <= 1'b1;
          end else begin
            o_mode <= 1'b0;
            {o_a, o_b, o_prime, o_Px, o_Py, o_m} <= {sh_a[MAX_BITS-1], sh_b[MAX_BITS-1],
              sh_prime[MAX_BITS-1], sh_px[MAX_BITS-1], sh_py[MAX_BITS-1], sh_m[MAX_BITS-1]};
            {sh_a, sh_b, sh_prime} <= {sh_a << 1, sh_b << 1, sh_prime << 1};
            {sh_px, sh_py, sh_m} <= {sh_px << 1, sh_py << 1, sh_m << 1};
            tx_cnt <= rx_nm1;
            state <= S_MP_DATA;
          end
        end
        S_MP_DATA: begin
          // tx_cnt = bits still to send after the one currently on the pins
          if (tx_cnt != 8'd0) begin
            {o_a, o_b, o_prime, o_Px, o_Py, o_m} <= {sh_a[MAX_BITS-1], sh_b[MAX_BITS-1],
              sh_prime[MAX_BITS-1], sh_px[MAX_BITS-1], sh_py[MAX_BITS-1], sh_m[MAX_BITS-1]};
            {sh_a, sh_b, sh_prime} <= {sh_a << 1, sh_b << 1, sh_prime << 1};
            {sh_px, sh_py, sh_m} <= {sh_px << 1, sh_py << 1, sh_m << 1};
            tx_cnt <= tx_cnt - 8'd1;
          end else begin
            {o_a, o_b, o_prime, o_Px, o_Py, o_m} <= 6'd0;
            state <= S_GAP;
          end
        end
        S_NP_VALID: begin
          o_nP_valid <= 1'b0;
          {o_nPx, o_nPy} <= {sh_px[MAX_BITS-1], sh_py[MAX_BITS-1]};
          {sh_px, sh_py} <= {sh_px << 1, sh_py << 1};
          tx_cnt <= rx_nm1;
          state <= S_NP_DATA;
        end
        S_NP_DATA: begin
          if (tx_cnt != 8'd0) begin
            {o_nPx, o_nPy} <= {sh_px[MAX_BITS-1], sh_py[MAX_BITS-1]};
            {sh_px, sh_py} <= {sh_px << 1, sh_py << 1};
            tx_cnt <= tx_cnt - 8'd1;
          end else begin
            {o_nPx, o_nPy} <= 2'd0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          tx_ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          tx_ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Receive side: channel 0 = mP, channel 1 = mnP.
  logic [1:0]                rx_valid, rx_bx, rx_by, rx_done;
  logic [1:0][MAX_BITS-1:0]  res_x, res_y;
`ifdef ECC_HOST_CHECK_EN
  logic [1:0] trunc_evt, over_evt;
`endif

  assign rx_valid = {i_mnP_valid, i_mP_valid};
  assign rx_bx    = {i_mnPx, i_mP_valid ? i_mPx : 1'b0};
  assign rx_by    = {i_mnPy, i_mPy};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rx
      logic [7:0]          cnt_reg;
      logic                ign_reg;
      logic                done_reg;
      logic [MAX_BITS-1:0] shx_reg, shy_reg, resx_reg, resy_reg;

      // Shift bits into a private shadow; publish only on the Nth bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= 8'd0;
          ign_reg <= 1'b0;
          done_reg <= 1'b0;
          shx_reg <= '0;
          shy_reg <= '0;
          resx_reg <= '0;
          resy_reg <= '0;
        end else begin
          done_reg <= 1'b0;
          if (rx_valid[gi]) begin
            if (!ign_reg) begin
              if (cnt_reg == rx_nm1) begin
                resx_reg <= {shx_reg[MAX_BITS-2:0], rx_bx[gi]};
                resy_reg <= {shy_reg[MAX_BITS-2:0], rx_by[gi]};
                done_reg <= 1'b1;
                shx_reg <= '0;
                shy_reg <= '0;
                cnt_reg <= 8'd0;
                ign_reg <= 1'b1;
              end else begin
                shx_reg <= {shx_reg[MAX_BITS-2:0], rx_bx[gi]};
                shy_reg <= {shy_reg[MAX_BITS-2:0], rx_by[gi]};
                cnt_reg <= cnt_reg + 8'd1;
              end
            end
          end else begin
            // valid low: any partial frame is discarded, next rise starts fresh
            shx_reg <= '0;
            shy_reg <= '0;
            cnt_reg <= 8'd0;
            ign_reg <= 1'b0;
          end
        end
      end

      assign res_x[gi]   = resx_reg;
      assign res_y[gi]   = resy_reg;
      assign rx_done[gi] = done_reg;
`ifdef ECC_HOST_CHECK_EN
      assign trunc_evt[gi] = !rx_valid[gi] && (cnt_reg != 8'd0);
      assign over_evt[gi]  = rx_valid[gi] && ign_reg;
`endif
    end
  endgenerate

  assign rx_mPx      = res_x[0];
  assign rx_mPy      = res_y[0];
  assign rx_mnPx     = res_x[1];
  assign rx_mnPy     = res_y[1];
  assign rx_mP_done  = rx_done[0];
  assign rx_mnP_done = rx_done[1];

`ifdef ECC_HOST_CHECK_EN
  logic err_reg;
  logic np_reject;
  assign np_reject = (state == S_IDLE) && tx_np_start && !tx_mp_start && !mode_sent;

  // Sticky protocol error: truncated/over-long RX frame or nP with no mode frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((|trunc_evt) || (|over_evt) || np_reject) begin
      err_reg <= 1'b1;
    end
  end
  assign rx_err = err_reg;
`else
  assign rx_err = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_serial_host.sv
// Directed testbench for ecc_serial_host (TX framing, RX deserializers, reset).
module tb_ecc_serial_host;
  logic clk, rst;
  logic tx_mp_start, tx_np_start;
  logic [1:0] tx_mode;
  logic [255:0] tx_a, tx_b, tx_prime, tx_Px, tx_Py, tx_m, tx_nPx, tx_nPy;
  logic tx_ready, o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m;
  logic o_nP_valid, o_nPx, o_nPy;
  logic i_mP_valid, i_mPx, i_mPy, i_mnP_valid, i_mnPx, i_mnPy;
  logic [255:0] rx_mPx, rx_mPy, rx_mnPx, rx_mnPy;
  logic rx_mP_done, rx_mnP_done, rx_err;

  int checks = 0;
  int errors = 0;

`ifdef ECC_HOST_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  ecc_serial_host #(.MAX_BITS(256)) dut (
    .clk(clk), .rst(rst), .tx_mp_start(tx_mp_start), .tx_np_start(tx_np_start),
    .tx_mode(tx_mode), .tx_a(tx_a), .tx_b(tx_b), .tx_prime(tx_prime),
    .tx_Px(tx_Px), .tx_Py(tx_Py), .tx_m(tx_m), .tx_nPx(tx_nPx), .tx_nPy(tx_nPy),
    .tx_ready(tx_ready), .o_m_P_valid(o_m_P_valid), .o_mode(o_mode), .o_a(o_a),
    .o_b(o_b), .o_prime(o_prime), .o_Px(o_Px), .o_Py(o_Py), .o_m(o_m),
    .o_nP_valid(o_nP_valid), .o_nPx(o_nPx), .o_nPy(o_nPy),
    .i_mP_valid(i_mP_valid), .i_mPx(i_mPx), .i_mPy(i_mPy),
    .i_mnP_valid(i_mnP_valid), .i_mnPx(i_mnPx), .i_mnPy(i_mnPy),
    .rx_mPx(rx_mPx), .rx_mPy(rx_mPy), .rx_mnPx(rx_mnPx), .rx_mnPy(rx_mnPy),
    .rx_mP_done(rx_mP_done), .rx_mnP_done(rx_mnP_done), .rx_err(rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({tx_ready, o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m,
         o_nP_valid, o_nPx, o_nPy} !== 12'h800) begin
      errors++;
      $display("FAIL reset_tx_outputs: got %b expected 100000000000",
               {tx_ready, o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m,
                o_nP_valid, o_nPx, o_nPy});
    end
    checks++;
    if ({rx_mPx, rx_mPy, rx_mnPx, rx_mnPy, rx_mP_done, rx_mnP_done, rx_err} !== '0) begin
      errors++;
      $display("FAIL reset_rx_outputs: got mPx=%0h mnPx=%0h done=%b%b err=%b expected all 0",
               rx_mPx, rx_mnPx, rx_mP_done, rx_mnP_done, rx_err);
    end
    rst = 1'b0;
    tick();
    $display("reset: tx_ready=%b", tx_ready);
  endtask

  // Sends one m/P frame and checks every cycle of it against the operands.
  task automatic run_mp_frame(input logic [1:0] mode, input logic [255:0] a, b, p, px, py, m,
                              input logic with_np);
    int n;
    n = 32 << mode;
    tx_mode = mode; tx_a = a; tx_b = b; tx_prime = p; tx_Px = px; tx_Py = py; tx_m = m;
    tx_nPx = '1; tx_nPy = '1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mp_ready_at_T: got %b expected 1", tx_ready);
    end
    tx_mp_start = 1'b1;
    tx_np_start = with_np;
    tick();  // T+1
    tx_mp_start = 1'b0;
    tx_np_start = 1'b0;
    tx_a = ~a; tx_b = ~b; tx_prime = ~p; tx_Px = ~px; tx_Py = ~py; tx_m = ~m; tx_mode = ~mode;
    checks++;
    if ({o_m_P_valid, tx_ready, o_mode, o_nP_valid, o_a, o_Px} !== 6'b100000) begin
      errors++;
      $display("FAIL mp_valid_T1: got valid,ready,mode,npv,a,px=%b expected 100000",
               {o_m_P_valid, tx_ready, o_mode, o_nP_valid, o_a, o_Px});
    end
    tick();  // T+2
    checks++;
    if ({o_m_P_valid, o_mode} !== {1'b0, mode[1]}) begin
      errors++;
      $display("FAIL mp_mode_bit1: got valid,mode=%b%b expected 0%b", o_m_P_valid, o_mode, mode[1]);
    end
    tick();  // T+3
    checks++;
    if ({o_mode, o_a, o_prime} !== {mode[0], 2'b00}) begin
      errors++;
      $display("FAIL mp_mode_bit0: got mode,a,prime=%b expected %b00", {o_mode, o_a, o_prime}, mode[0]);
    end
    for (int k = 0; k < n; k++) begin
      tick();  // T+4+k
      checks++;
      if ({o_a, o_b, o_prime, o_Px, o_Py, o_m, o_mode, o_nP_valid, o_nPx, tx_ready} !==
          {a[n-1-k], b[n-1-k], p[n-1-k], px[n-1-k], py[n-1-k], m[n-1-k], 4'b0000}) begin
        errors++;
        $display("FAIL mp_data_bit%0d: got a,b,p,px,py,m,mode,npv,npx,rdy=%b expected %b0000", n-1-k,
                 {o_a, o_b, o_prime, o_Px, o_Py, o_m, o_mode, o_nP_valid, o_nPx, tx_ready},
                 {a[n-1-k], b[n-1-k], p[n-1-k], px[n-1-k], py[n-1-k], m[n-1-k]});
      end
    end
    tick();  // GAP
    checks++;
    if ({o_a, o_b, o_prime, o_Px, o_Py, o_m, o_m_P_valid, tx_ready} !== 8'd0) begin
      errors++;
      $display("FAIL mp_gap: got data,valid,ready=%b expected 00000000",
               {o_a, o_b, o_prime, o_Px, o_Py, o_m, o_m_P_valid, tx_ready});
    end
    tick();  // T+5+N
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mp_ready_end: got %b expected 1", tx_ready);
    end
    $display("mp frame: mode=%b N=%0d np_also=%b", mode, n, with_np);
  endtask

  task automatic run_np_frame(input int n, input logic [255:0] x, y);
    tx_nPx = x;
    tx_nPy = y;
    tx_np_start = 1'b1;
    tick();  // T+1
    tx_np_start = 1'b0;
    tx_nPx = ~x;
    tx_nPy = ~y;
    checks++;
    if ({o_nP_valid, tx_ready, o_nPx, o_nPy, o_m_P_valid} !== 5'b10000) begin
      errors++;
      $display("FAIL np_valid_T1: got npv,ready,x,y,mpv=%b expected 10000",
               {o_nP_valid, tx_ready, o_nPx, o_nPy, o_m_P_valid});
    end
    for (int k = 0; k < n; k++) begin
      tick();  // T+2+k
      checks++;
      if ({o_nPx, o_nPy, o_nP_valid, tx_ready} !== {x[n-1-k], y[n-1-k], 2'b00}) begin
        errors++;
        $display("FAIL np_data_bit%0d: got x,y,npv,rdy=%b expected %b%b00", n-1-k,
                 {o_nPx, o_nPy, o_nP_valid, tx_ready}, x[n-1-k], y[n-1-k]);
      end
    end
    tick();  // GAP
    checks++;
    if ({o_nPx, o_nPy, o_nP_valid, tx_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL np_gap: got %b expected 0000", {o_nPx, o_nPy, o_nP_valid, tx_ready});
    end
    tick();  // T+3+N
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL np_ready_end: got %b expected 1", tx_ready);
    end
    $display("np frame: N=%0d nPx=%0h", n, x);
  endtask

  task automatic test_mp32();
    run_mp_frame(2'b00, 256'h1, 256'h7, 256'hFFFFFFFB, 256'h80000001, 256'h3C3C_0F0F,
                 256'hA5A5A5A5, 1'b0);
  endtask

  task automatic test_np32();
    run_np_frame(32, 256'h12345678, 256'h9ABCDEF0);
  endtask

  task automatic test_mp128_np128();
    // upper 128 bits hold junk that must never reach the pins
    run_mp_frame(2'b10, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978},
                 {128'hDEAD, 128'h8000_0000_0000_0000_0000_0000_0000_0001},
                 {128'h1, 128'hFFFF_FFFF_FFFF_FFFD_FFFF_FFFF_FFFF_FFFF},
                 {128'h5, 128'h1618_3F2C_ACC4_9C0D_4EBD_FE5A_A3C1_0B1E},
                 {128'hA, 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF},
                 {128'h7, 128'hC000_0000_0000_0000_0000_0000_0000_0003}, 1'b0);
    run_np_frame(128, {128'hFFFF, 128'h8765_4321_0FED_CBA9_1357_9BDF_2468_ACE0},
                 {128'h1, 128'h0000_0001_0000_0002_0000_0004_8000_0008});
  endtask

  task automatic test_mp256();
    run_mp_frame(2'b11, 256'h2, 256'h5AC635D8AA3A93E7B3EBBD55769886BC651D06B0CC53B0F63BCE3C3E27D2604B,
                 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF,
                 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296,
                 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5,
                 256'h8000000000000000000000000000000000000000000000000000000000000001, 1'b0);
  endtask

  task automatic test_rx_concurrent();
    logic [31:0] mpx, mpy, mnx, mny;
    mpx = 32'hDEADBEEF; mpy = 32'h01234567; mnx = 32'h0BADF00D; mny = 32'h89ABCDEF;
    for (int c = 0; c < 37; c++) begin
      i_mP_valid = 1'b0; i_mPx = 1'b0; i_mPy = 1'b0;
      i_mnP_valid = 1'b0; i_mnPx = 1'b0; i_mnPy = 1'b0;
      if (c < 32) begin
        i_mP_valid = 1'b1; i_mPx = mpx[31-c]; i_mPy = mpy[31-c];
      end
      if (c >= 3 && c < 35) begin
        i_mnP_valid = 1'b1; i_mnPx = mnx[34-c]; i_mnPy = mny[34-c];
      end
      checks++;
      if ({rx_mP_done, rx_mnP_done} !== {c == 32, c == 35}) begin
        errors++;
        $display("FAIL rx_done_cycle%0d: got mP,mnP=%b%b expected %b%b", c,
                 rx_mP_done, rx_mnP_done, c == 32, c == 35);
      end
      if (c < 32) begin
        checks++;
        if (rx_mPx !== 256'h0) begin
          errors++;
          $display("FAIL rx_partial_cycle%0d: got %0h expected 0", c, rx_mPx);
        end
      end
      if (c == 32) begin
        checks++;
        if ({rx_mPx, rx_mPy} !== {224'h0, mpx, 224'h0, mpy}) begin
          errors++;
          $display("FAIL rx_mP_word: got x=%0h y=%0h expected x=%0h y=%0h", rx_mPx, rx_mPy, mpx, mpy);
        end
      end
      tick();
    end
    checks++;
    if ({rx_mnPx, rx_mnPy, rx_err} !== {224'h0, mnx, 224'h0, mny, 1'b0}) begin
      errors++;
      $display("FAIL rx_mnP_word: got x=%0h y=%0h err=%b expected x=%0h y=%0h err=0",
               rx_mnPx, rx_mnPy, rx_err, mnx, mny);
    end
    $display("rx concurrent: mPx=%0h mnPx=%0h", rx_mPx, rx_mnPx);
  endtask

  task automatic test_rx_truncated();
    logic [31:0] v;
    for (int c = 0; c < 45; c++) begin
      i_mP_valid = (c < 10); i_mPx = (c < 10); i_mPy = 1'b1;
      checks++;
      if (rx_mP_done !== 1'b0) begin
        errors++;
        $display("FAIL trunc_no_done_cycle%0d: got 1 expected 0", c);
      end
      tick();
    end
    checks++;
    if ({rx_mPx, rx_err} !== {256'hDEADBEEF, CHECK_EN}) begin
      errors++;
      $display("FAIL trunc_hold: got mPx=%0h err=%b expected mPx=deadbeef err=%b", rx_mPx, rx_err, CHECK_EN);
    end
    // a clean frame afterwards must not inherit the discarded bits
    v = 32'h5555AAAA;
    for (int c = 0; c < 34; c++) begin
      i_mP_valid = (c < 32); i_mPx = 1'b0; i_mPy = 1'b0;
      if (c < 32) begin
        i_mPx = v[31-c]; i_mPy = ~v[31-c];
      end
      tick();
      if (c == 31) begin
        checks++;
        if ({rx_mP_done, rx_mPx, rx_mPy} !== {1'b1, 224'h0, v, 224'h0, ~v}) begin
          errors++;
          $display("FAIL trunc_recover: got done=%b x=%0h y=%0h expected done=1 x=%0h y=%0h",
                   rx_mP_done, rx_mPx, rx_mPy, v, ~v);
        end
      end
    end
    $display("rx truncated: mPx=%0h err=%b", rx_mPx, rx_err);
  endtask

  task automatic test_rx_overlong();
    logic [31:0] v;
    v = 32'hCAFEF00D;
    for (int c = 0; c < 37; c++) begin
      i_mP_valid = (c < 34); i_mPx = 1'b1; i_mPy = 1'b0;
      if (c < 32) i_mPx = v[31-c];
      checks++;
      if (rx_mP_done !== (c == 32)) begin
        errors++;
        $display("FAIL overlong_done_cycle%0d: got %b expected %b", c, rx_mP_done, c == 32);
      end
      tick();
    end
    i_mP_valid = 1'b0; i_mPx = 1'b0;
    checks++;
    if ({rx_mPx, rx_err} !== {224'h0, v, CHECK_EN}) begin
      errors++;
      $display("FAIL overlong_word: got %0h err=%b expected %0h err=%b", rx_mPx, rx_err, v, CHECK_EN);
    end
    $display("rx overlong: mPx=%0h", rx_mPx);
  endtask

  task automatic test_reset_mid_frame();
    tx_mode = 2'b00; tx_a = '1; tx_b = '1; tx_prime = '1; tx_Px = '1; tx_Py = '1; tx_m = '1;
    tx_mp_start = 1'b1;
    tick();
    tx_mp_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();  // T+10, inside MP_DATA
    checks++;
    if ({o_a, o_m} !== 2'b11) begin
      errors++;
      $display("FAIL midframe_active: got a,m=%b expected 11", {o_a, o_m});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nP_valid, o_nPx, o_nPy,
         tx_ready} !== 12'h001) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %b expected 000000000001",
               {o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nP_valid, o_nPx, o_nPy, tx_ready});
    end
    checks++;
    if ({rx_mPx, rx_mnPx, rx_err} !== '0) begin
      errors++;
      $display("FAIL midframe_reset_rx: got mPx=%0h mnPx=%0h err=%b expected 0", rx_mPx, rx_mnPx, rx_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({o_a, o_m, o_m_P_valid, tx_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midframe_after_reset: got %b expected 0001", {o_a, o_m, o_m_P_valid, tx_ready});
    end
    $display("reset mid-frame: tx_ready=%b", tx_ready);
  endtask

  task automatic test_np_without_mode();
    tx_nPx = '1; tx_nPy = '1;
    tx_np_start = 1'b1;
    tick();
    tx_np_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if ({o_nP_valid, o_nPx, o_nPy, o_m_P_valid, tx_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL np_no_mode_cycle%0d: got npv,x,y,mpv,rdy=%b expected 00001", c,
                 {o_nP_valid, o_nPx, o_nPy, o_m_P_valid, tx_ready});
      end
      tick();
    end
    checks++;
    if (rx_err !== CHECK_EN) begin
      errors++;
      $display("FAIL np_no_mode_err: got %b expected %b", rx_err, CHECK_EN);
    end
    $display("np without mode: ignored, rx_err=%b", rx_err);
  endtask

  task automatic test_simultaneous_start();
    run_mp_frame(2'b00, 256'h3, 256'h8000_0000, 256'hFFFF_FFFB, 256'h1234_5678,
                 256'h0F0F_F0F0, 256'h6, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({o_nP_valid, tx_ready} !== 2'b01) begin
        errors++;
        $display("FAIL simultaneous_np_dropped_cycle%0d: got npv,rdy=%b expected 01", c,
                 {o_nP_valid, tx_ready});
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    tx_mp_start = 1'b0; tx_np_start = 1'b0; tx_mode = 2'b00;
    tx_a = '0; tx_b = '0; tx_prime = '0; tx_Px = '0; tx_Py = '0; tx_m = '0;
    tx_nPx = '0; tx_nPy = '0;
    i_mP_valid = 1'b0; i_mPx = 1'b0; i_mPy = 1'b0;
    i_mnP_valid = 1'b0; i_mnPx = 1'b0; i_mnPy = 1'b0;
    test_reset();
    test_mp32();
    test_np32();
    test_rx_concurrent();
    test_rx_truncated();
    test_rx_overlong();
    test_mp128_np128();
    test_mp256();
    test_reset_mid_frame();
    test_np_without_mode();
    test_simultaneous_start();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
